switch_mcu_fetch: RTL

//   Instruction fetch stage of the switch MCU core, directly upstream of the instruction decoder.

---
 rtl/switch_mcu_fetch_if.sv | 46 ++++
 rtl/switch_mcu_fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/switch_mcu_fetch_if.sv
// Instruction-fetch stage bundle: imem req/ack port, execute-slot controls and decoder-facing outputs.
// The master modport belongs to the fetch stage; the slave modport is the memory/decoder side.
interface switch_mcu_fetch_if;
  logic        out_imem_req;
  logic [31:0] out_imem_addr;
  logic        in_imem_ack;
  logic [31:0] in_imem_rdata;
  logic        in_stall;
  logic        in_redirect_valid;
  logic [31:0] in_redirect_pc;
  logic [31:0] out_inst;
  logic        out_inst_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_cycle_cnt;
  logic        out_misalign_err;

  modport master (
    output out_imem_req,
    output out_imem_addr,
    input  in_imem_ack,
    input  in_imem_rdata,
    input  in_stall,
    input  in_redirect_valid,
    input  in_redirect_pc,
    output out_inst,
    output out_inst_valid,
    output out_pc,
    output out_cycle_cnt,
    output out_misalign_err
  );

  modport slave (
    input  out_imem_req,
    input  out_imem_addr,
    output in_imem_ack,
    output in_imem_rdata,
    output in_stall,
    output in_redirect_valid,
    output in_redirect_pc,
    input  out_inst,
    input  out_inst_valid,
    input  out_pc,
    input  out_cycle_cnt,
    input  out_misalign_err
  );
endinterface

// File: rtl/switch_mcu_fetch.sv
// Fetch stage of the switch MCU: holds the PC, fetches one word per slot, sequences the
// multi-cycle execute slot and applies the last branch/jump redirect seen in that slot.
module switch_mcu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 4,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input logic                 in_clk,
  input logic                 in_rst,
  switch_mcu_fetch_if.master  bus
);

  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] IDLE_CNT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] redir_pc_q;
  logic        redir_pend_q;
  logic        req_q;
  logic        valid_q;
  logic        err_q;
  logic [3:0]  cnt_q;

  logic        redir_ok;
  logic        redir_bad;
  logic        cnt_advance;
  logic        slot_done;
  logic [31:0] pc_d;

  always_comb begin
    redir_ok    = bus.in_redirect_valid && (bus.in_redirect_pc[1:0] == 2'b00);
    redir_bad   = bus.in_redirect_valid && (bus.in_redirect_pc[1:0] != 2'b00);
    // Count 0 never stalls so the decoder sees exactly one latch cycle per instruction.
    cnt_advance = (cnt_q == 4'd0) || !bus.in_stall;
    slot_done   = (cnt_q == LAST_CNT) && !bus.in_stall;
    if (redir_ok) begin
      pc_d = bus.in_redirect_pc;
    end else if (redir_pend_q) begin
      pc_d = redir_pc_q;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      redir_pc_q   <= 32'h0;
      redir_pend_q <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= IDLE_CNT;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.in_imem_ack) begin
            req_q        <= 1'b0;
            inst_q       <= bus.in_imem_rdata;
            valid_q      <= 1'b1;
            cnt_q        <= 4'd0;
            redir_pend_q <= 1'b0;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (redir_bad) begin
            state_q      <= ST_HALT;
            inst_q       <= NOP_INST;
            valid_q      <= 1'b0;
            cnt_q        <= IDLE_CNT;
            err_q        <= 1'b1;
            redir_pend_q <= 1'b0;
          end else if (slot_done) begin
            state_q      <= ST_FETCH;
            pc_q         <= pc_d;
            inst_q       <= NOP_INST;
            valid_q      <= 1'b0;
            cnt_q        <= IDLE_CNT;
            req_q        <= 1'b1;
            redir_pend_q <= 1'b0;
          end else begin
            if (cnt_advance) begin
              cnt_q <= cnt_q + 4'd1;
            end
            if (redir_ok) begin
              redir_pend_q <= 1'b1;
              redir_pc_q   <= bus.in_redirect_pc;
            end
          end
        end
        ST_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          cnt_q   <= IDLE_CNT;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.out_imem_req     = req_q;
  assign bus.out_imem_addr    = pc_q;
  assign bus.out_pc           = pc_q;
  assign bus.out_inst         = inst_q;
  assign bus.out_inst_valid   = valid_q;
  assign bus.out_cycle_cnt    = cnt_q;
  assign bus.out_misalign_err = err_q;

endmodule
